// File: rtl/ad5791_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : ad5791_init_seq
// Description : Bring-up sequencer and request arbiter in front of the
//               axis_AD5791 serializer. After reset it waits POR_CYCLES,
//               issues a software reset, waits POR_CYCLES again, then writes
//               the control and clearcode registers. Afterwards it forwards
//               20-bit user samples as DAC-register writes and arbitrates
//               them against software-CLR and re-initialisation requests.
// Ports       : s_axis_aclk     - clock
//               s_axis_aresetn  - synchronous active-low reset
//               s_axis_*        - 20-bit user sample stream (slave)
//               m_axis_*        - 24-bit word stream to the serializer
//               reinit          - pulse: request full re-initialisation
//               sw_clr          - pulse: request software CLR
//               init_done       - high in RUN or SAMPLE
//               busy            - high whenever the sequencer is not in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module ad5791_init_seq #(
    parameter int          POR_CYCLES = 1000,
    parameter logic [19:0] CTRL_WORD  = 20'h00012,
    parameter logic [19:0] CLEARCODE  = 20'h80000
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,
    input  logic [19:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic        reinit,
    input  logic        sw_clr,
    output logic        init_done,
    output logic        busy
);

    localparam int                CNT_W    = $clog2(POR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POR_CYCLES - 1);

    localparam logic [23:0] WORD_SWRST = 24'h400004;
    localparam logic [23:0] WORD_SWCLR = 24'h400002;
    localparam logic [23:0] WORD_CTRL  = {4'b0010, CTRL_WORD};
    localparam logic [23:0] WORD_CLRC  = {4'b0011, CLEARCODE};

    localparam logic [2:0] ST_POR_WAIT = 3'd0;
    localparam logic [2:0] ST_SWRST    = 3'd1;
    localparam logic [2:0] ST_RST_WAIT = 3'd2;
    localparam logic [2:0] ST_CTRL     = 3'd3;
    localparam logic [2:0] ST_CLRC     = 3'd4;
    localparam logic [2:0] ST_RUN      = 3'd5;
    localparam logic [2:0] ST_SAMPLE   = 3'd6;
    localparam logic [2:0] ST_SWCLR    = 3'd7;

    logic [2:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             reinit_pend;
    logic             clr_pend;
    logic             accept;
    logic             svc_reinit;
    logic             svc_clr;

    assign accept     = m_axis_tvalid && m_axis_tready;
    // Requests are only serviced from RUN; reinit outranks clr.
    assign svc_reinit = (state == ST_RUN) && reinit_pend;
    assign svc_clr    = (state == ST_RUN) && !reinit_pend && clr_pend;

    assign s_axis_tready = (state == ST_RUN) && !reinit_pend && !clr_pend;
    assign init_done     = (state == ST_RUN) || (state == ST_SAMPLE);
    assign busy          = (state != ST_RUN);

    // Main sequencer. Each send state's word is loaded on the transition
    // into that state so the output stays fully registered.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state         <= ST_POR_WAIT;
            wait_cnt      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            case (state)
                ST_POR_WAIT: begin
                    if (wait_cnt == CNT_LAST) begin
                        state         <= ST_SWRST;
                        m_axis_tdata  <= WORD_SWRST;
                        m_axis_tvalid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_SWRST: begin
                    if (accept) begin
                        state         <= ST_RST_WAIT;
                        wait_cnt      <= '0;
                        m_axis_tvalid <= 1'b0;
                    end
                end
                ST_RST_WAIT: begin
                    if (wait_cnt == CNT_LAST) begin
                        state         <= ST_CTRL;
                        m_axis_tdata  <= WORD_CTRL;
                        m_axis_tvalid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_CTRL: begin
                    // Back-to-back: tvalid stays high into CLRC.
                    if (accept) begin
                        state        <= ST_CLRC;
                        m_axis_tdata <= WORD_CLRC;
                    end
                end
                ST_RUN: begin
                    if (svc_reinit) begin
                        state         <= ST_SWRST;
                        m_axis_tdata  <= WORD_SWRST;
                        m_axis_tvalid <= 1'b1;
                    end else if (svc_clr) begin
                        state         <= ST_SWCLR;
                        m_axis_tdata  <= WORD_SWCLR;
                        m_axis_tvalid <= 1'b1;
                    end else if (s_axis_tvalid) begin
                        // No pending request here, so s_axis_tready is high.
                        state         <= ST_SAMPLE;
                        m_axis_tdata  <= {4'b0001, s_axis_tdata};
                        m_axis_tvalid <= 1'b1;
                    end
                end
                ST_CLRC, ST_SAMPLE, ST_SWCLR: begin
                    if (accept) begin
                        state         <= ST_RUN;
                        m_axis_tvalid <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_POR_WAIT;
                    wait_cnt      <= '0;
                    m_axis_tvalid <= 1'b0;
                end
            endcase
        end
    end

    // Pending request flags. A pulse landing on the edge that services (or
    // supersedes) the same request is merged into it rather than re-queued.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            reinit_pend <= 1'b0;
            clr_pend    <= 1'b0;
        end else if (svc_reinit) begin
            reinit_pend <= 1'b0;
            clr_pend    <= 1'b0;
        end else begin
            if (reinit) begin
                reinit_pend <= 1'b1;
            end
            if (svc_clr) begin
                clr_pend <= 1'b0;
            end else if (sw_clr) begin
                clr_pend <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ad5791_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad5791_init_seq
// Description : Self-checking bench for ad5791_init_seq. A queue-based model
//               (waits and words still to be issued) predicts every output on
//               every cycle; directed scenarios pin the model with literal
//               expectations, then a randomized phase exercises arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad5791_init_seq;

    localparam int POR = 4;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [19:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        reinit;
    logic        sw_clr;
    logic        init_done;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ad5791_init_seq #(
        .POR_CYCLES (POR),
        .CTRL_WORD  (20'h00012),
        .CLEARCODE  (20'h80000)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (aresetn),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .reinit         (reinit),
        .sw_clr         (sw_clr),
        .init_done      (init_done),
        .busy           (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Work still to be issued: q_wait>0 is an idle gap of that many cycles,
    // q_wait==0 is a word (q_word) which is a user sample if q_samp.
    int          q_wait[$];
    logic [23:0] q_word[$];
    bit          q_samp[$];
    bit          m_rp, m_cp;
    bit          model_valid = 1'b0;
    logic [23:0] log_q[$];

    function automatic void push_item(input int w, input logic [23:0] d, input bit s);
        q_wait.push_back(w);
        q_word.push_back(d);
        q_samp.push_back(s);
    endfunction

    function automatic void push_init(input bit with_por);
        if (with_por) push_item(POR, 24'h0, 1'b0);
        push_item(0, 24'h400004, 1'b0);
        push_item(POR, 24'h0, 1'b0);
        push_item(0, 24'h200012, 1'b0);
        push_item(0, 24'h380000, 1'b0);
    endfunction

    function automatic void pop_item();
        void'(q_wait.pop_front());
        void'(q_word.pop_front());
        void'(q_samp.pop_front());
    endfunction

    function automatic logic [23:0] log_at(input int i);
        return (i < log_q.size()) ? log_q[i] : 24'hFFFFFF;
    endfunction

    always @(negedge clk) begin : cmp
        bit e_tv, e_sr, e_id, e_bz, svc_r, svc_c;
        logic [23:0] e_td;
        if (model_valid) begin
            e_td = 24'h0;
            if (q_wait.size() == 0) begin
                e_tv = 1'b0; e_sr = !m_rp && !m_cp; e_id = 1'b1; e_bz = 1'b0;
            end else if (q_wait[0] > 0) begin
                e_tv = 1'b0; e_sr = 1'b0; e_id = 1'b0; e_bz = 1'b1;
            end else begin
                e_tv = 1'b1; e_td = q_word[0]; e_sr = 1'b0; e_id = q_samp[0]; e_bz = 1'b1;
            end
            chk("m_tvalid", 32'(m_tvalid), 32'(e_tv));
            if (e_tv) chk("m_tdata", 32'(m_tdata), 32'(e_td));
            chk("s_tready", 32'(s_tready), 32'(e_sr));
            chk("init_done", 32'(init_done), 32'(e_id));
            chk("busy", 32'(busy), 32'(e_bz));
            if (aresetn && m_tvalid && m_tready) log_q.push_back(m_tdata);
        end
        // advance the model with the inputs the next rising edge will see
        if (!aresetn) begin
            q_wait.delete(); q_word.delete(); q_samp.delete();
            push_init(1'b1);
            m_rp = 1'b0; m_cp = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            svc_r = 1'b0; svc_c = 1'b0;
            if (q_wait.size() == 0) begin
                if (m_rp) begin
                    svc_r = 1'b1; push_init(1'b0);
                end else if (m_cp) begin
                    svc_c = 1'b1; push_item(0, 24'h400002, 1'b0);
                end else if (s_tvalid) begin
                    push_item(0, {4'b0001, s_tdata}, 1'b1);
                end
            end else if (q_wait[0] > 0) begin
                q_wait[0] = q_wait[0] - 1;
                if (q_wait[0] == 0) pop_item();
            end else if (m_tready) begin
                pop_item();
            end
            if (svc_r) begin
                m_rp = 1'b0; m_cp = 1'b0;
            end else begin
                if (reinit) m_rp = 1'b1;
                if (svc_c) m_cp = 1'b0;
                else if (sw_clr) m_cp = 1'b1;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sready();
        int n = 0;
        while (!s_tready && n < 200) begin step(); n++; end
        if (!s_tready) chk("timeout_s_tready", 32'(s_tready), 32'd1);
    endtask

    task automatic send_sample(input logic [19:0] d);
        s_tdata  = d;
        s_tvalid = 1'b1;
        wait_sready();
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic wait_accepts(input int k);
        int n = 0;
        int got = 0;
        while (got < k && n < 500) begin
            if (m_tvalid && m_tready) got++;
            step();
            n++;
        end
        if (got < k) chk("timeout_accepts", 32'(got), 32'(k));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_m_tdata"}, 32'(m_tdata), 32'd0);
        chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic chk_init_words(input int idx, input string tag);
        chk({tag, "_w0"}, 32'(log_at(idx)), 32'h400004);
        chk({tag, "_w1"}, 32'(log_at(idx + 1)), 32'h200012);
        chk({tag, "_w2"}, 32'(log_at(idx + 2)), 32'h380000);
    endtask

    initial begin
        int n;
        int idx;
        int stall;
        aresetn = 1'b0; s_tdata = '0; s_tvalid = 1'b0;
        m_tready = 1'b1; reinit = 1'b0; sw_clr = 1'b0;
        step(); step();
        chk_reset_vals("rst");
        aresetn = 1'b1;

        // power-on wait, software reset, gap, control, clearcode
        n = 0;
        while (!m_tvalid && n < 100) begin step(); n++; end
        chk("por_wait_cycles", 32'(n), 32'd4);
        wait_accepts(1);
        n = 0;
        while (!m_tvalid && n < 100) begin step(); n++; end
        chk("rst_wait_cycles", 32'(n), 32'd4);
        wait_accepts(2);
        chk("init_done_after_clrc", 32'(init_done), 32'd1);
        chk_init_words(0, "boot");

        // two samples, one-cycle latency, no new acceptance while outstanding
        send_sample(20'h00601);
        chk("smp1_tvalid", 32'(m_tvalid), 32'd1);
        chk("smp1_tdata", 32'(m_tdata), 32'h100601);
        chk("smp1_s_tready", 32'(s_tready), 32'd0);
        wait_accepts(1);
        send_sample(20'h00602);
        chk("smp2_tdata", 32'(m_tdata), 32'h100602);
        chk("smp2_s_tready", 32'(s_tready), 32'd0);
        wait_accepts(1);

        // serializer stall for 50 cycles
        m_tready = 1'b0;
        send_sample(20'h00603);
        idx = log_q.size();
        repeat (50) step();
        chk("stall_tvalid", 32'(m_tvalid), 32'd1);
        chk("stall_tdata", 32'(m_tdata), 32'h100603);
        chk("stall_s_tready", 32'(s_tready), 32'd0);
        chk("stall_no_accept", 32'(log_q.size()), 32'(idx));
        m_tready = 1'b1;
        step();
        chk("stall_release_tvalid", 32'(m_tvalid), 32'd0);
        repeat (3) step();
        chk("stall_one_accept", 32'(log_q.size()), 32'(idx + 1));

        // software CLR ahead of a waiting sample
        idx = log_q.size();
        sw_clr = 1'b1;
        step();
        sw_clr = 1'b0;
        send_sample(20'h00604);
        wait_accepts(1);
        chk("clr_word", 32'(log_at(idx)), 32'h400002);
        chk("clr_then_sample", 32'(log_at(idx + 1)), 32'h100604);

        // reinit and sw_clr together: CLR is superseded
        idx = log_q.size();
        reinit = 1'b1; sw_clr = 1'b1;
        step();
        reinit = 1'b0; sw_clr = 1'b0;
        wait_accepts(3);
        chk_init_words(idx, "reinit");
        repeat (3) step();
        chk("reinit_no_clr", 32'(log_q.size()), 32'(idx + 3));
        chk("reinit_init_done", 32'(init_done), 32'd1);
        chk("reinit_busy", 32'(busy), 32'd0);

        // reset while a DAC word is outstanding
        m_tready = 1'b0;
        send_sample(20'h00605);
        step();
        aresetn = 1'b0;
        step();
        chk_reset_vals("midrst");
        aresetn = 1'b1;
        m_tready = 1'b1;
        idx = log_q.size();
        wait_accepts(3);
        chk_init_words(idx, "midrst");
        chk("midrst_init_done", 32'(init_done), 32'd1);

        // randomized arbitration traffic
        stall = 0;
        for (int i = 0; i < 4000; i++) begin
            s_tvalid = ($urandom_range(0, 1) == 1);
            s_tdata  = 20'($urandom);
            reinit   = ($urandom_range(0, 149) == 0);
            sw_clr   = ($urandom_range(0, 39) == 0);
            if (stall > 0) begin
                m_tready = 1'b0;
                stall--;
            end else begin
                m_tready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 99) == 0) stall = $urandom_range(1, 60);
            end
            aresetn = ($urandom_range(0, 1499) != 0);
            step();
        end
        s_tvalid = 1'b0; reinit = 1'b0; sw_clr = 1'b0;
        m_tready = 1'b1; aresetn = 1'b1;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
